imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts instruction bits [31:7] plus a 3-bit format select, and produces the sign-extended immediate at DATA_WIDTH (32 or 64).
- Adds U-type support, illegal-format detection, a valid/ready handshake with backpressure, flush, a configurable register depth and a saturating illegal-format counter.
- Sits between fetch/decode and the execute-operand mux.

Parameters:
- DATA_WIDTH, 32, immediate output width; legal values 32 or 64.
- PIPE_DEPTH, 1, number of register stages; legal values 1..4; latency in cycles.
- TAG_WIDTH, 32, width of the sideband tag (typically PC) carried alongside each immediate.
- ERRCNT_WIDTH, 8, width of the saturating illegal-format counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  drop all in-flight entries and any input this cycle.
- in_valid  input  1  input entry valid.
- in_ready  output  1  block can accept an entry this cycle.
- instr  input  25  instruction bits [31:7], indexed [31:7].
- immsrc  input  3  format select.
- in_tag  input  TAG_WIDTH  sideband tag, passed through unchanged.
- out_valid  output  1  output entry valid.
- out_ready  input  1  consumer accepts the output entry.
- immext  output  DATA_WIDTH  extended immediate.
- out_tag  output  TAG_WIDTH  tag of the output entry.
- out_illegal  output  1  output entry had an illegal immsrc.
- err_count  output  ERRCNT_WIDTH  saturating count of accepted illegal entries.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at a rising edge): all stage valids=0, out_valid=0, immext=0, out_tag=0, out_illegal=0, err_count=0. Reset mid-stream discards every in-flight entry, with no partial outputs.
- Format decode (combinational, ahead of stage 1). S = instr[31] replicated to DATA_WIDTH:
  - 000 I: S, instr[31:20].
  - 001 S: S, instr[31:25], instr[11:7].
  - 010 B: S, instr[7], instr[30:25], instr[11:8], 0.
  - 011 J: S, instr[19:12], instr[20], instr[30:21], 0.
  - 100 U: S, instr[31:12], 12'b0. At DATA_WIDTH=64, bits 63:32 equal instr[31].
  - 101: optional CSR format (see Optional Feature); otherwise illegal.
  - 110, 111: illegal.
- Illegal formats: immext=0 and illegal flag=1 for that entry.
- Pipeline structure:
  - PIPE_DEPTH stages, each holding valid, imm, tag, illegal.
  - Stage k ready = !valid_k || ready_(k+1).
  - Last stage ready = out_ready; in_ready = stage-1 ready.
  - out_* reflect the last stage.
- Latency and throughput: exactly PIPE_DEPTH cycles when unstalled; one entry per cycle sustained.
- Transfers:
  - A handshake (in_valid && in_ready && !flush) loads stage 1.
  - A stage advances when its successor is ready.
  - Entries are never reordered, duplicated or dropped except by flush.
- Stall: with out_ready=0 the block fills to PIPE_DEPTH entries, then deasserts in_ready. Outputs hold stable while out_valid && !out_ready.
- Flush:
  - At the clock edge, all stage valids clear and the input is dropped regardless of in_valid/in_ready.
  - err_count is not incremented for a flushed input and is not cleared by flush.
  - out_valid=0 the cycle after flush.
  - flush and rst_n=0 together: reset dominates, with identical result.
- err_count:
  - Increments by 1 on each accepted (non-flushed) handshake whose immsrc is illegal.
  - Saturates at all-ones; never wraps.
- Simultaneous fill/drain: a full pipe with out_ready=1 accepts a new input in the same cycle (full throughput, no bubble).

Optional Feature:
- Macro: IMMGEN_CSR_EN.
- Defined: immsrc 101 selects the CSR zimm format, immext = zero-extension of instr[19:15]; illegal flag=0.
- Undefined: 101 is illegal (immext=0, out_illegal=1, err_count increments).
- All other encodings are unaffected either way.

Test Plan:
- DATA_WIDTH=32, PIPE_DEPTH=1: instr=0xFFF00093>>7, immsrc=000 -> one cycle later out_valid=1, immext=0xFFFFFFFF, out_illegal=0.
- B-type instr=0xFE000EE3, immsrc=010 -> immext=0xFFFFFFFC. J-type instr=0x0040006F, immsrc=011 -> immext=0x00000004.
- DATA_WIDTH=64: instr=0x800000B7, immsrc=100 -> immext=0xFFFFFFFF80000000.
- PIPE_DEPTH=2, out_ready=0, push tags 1,2,3 back-to-back:
  - in_ready drops after tags 1,2 are accepted.
  - Raising out_ready yields tags 1,2,3 in order with stable data during stall.
- Pipeline holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, nothing from that input ever appears, err_count unchanged.
- ERRCNT_WIDTH=2, push five immsrc=110 entries:
  - Each yields immext=0, out_illegal=1.
  - err_count goes 1,2,3,3,3.
  - With IMMGEN_CSR_EN, immsrc=101 and instr[19:15]=0x1F -> immext=0x1F, no count.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined sign-extending immediate generator with valid/ready
//            handshake, flush and saturating illegal-format counter.
//            Define IMMGEN_CSR_EN to decode immsrc 101 as CSR zimm.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_DEPTH   = 1,
  parameter int TAG_WIDTH    = 32,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:7]             instr,
  input  logic [2:0]              immsrc,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   immext,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_illegal,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  localparam logic [2:0] c_fmt_i   = 3'b000;
  localparam logic [2:0] c_fmt_s   = 3'b001;
  localparam logic [2:0] c_fmt_b   = 3'b010;
  localparam logic [2:0] c_fmt_j   = 3'b011;
  localparam logic [2:0] c_fmt_u   = 3'b100;
  localparam logic [2:0] c_fmt_csr = 3'b101;

  logic [31:0]           w_imm32;
  logic                  w_sign;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_dec_imm;

  // Decode to a 32-bit value plus the bit used to extend it, so the upper
  // half at 64 bits follows the format (sign for most, zero for zimm).
  always_comb begin
    w_imm32   = '0;
    w_sign    = 1'b0;
    w_illegal = 1'b0;
    case (immsrc)
      c_fmt_i: begin
        w_imm32 = {{20{instr[31]}}, instr[31:20]};
        w_sign  = instr[31];
      end
      c_fmt_s: begin
        w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_sign  = instr[31];
      end
      c_fmt_b: begin
        w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        w_sign  = instr[31];
      end
      c_fmt_j: begin
        w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        w_sign  = instr[31];
      end
      c_fmt_u: begin
        w_imm32 = {instr[31:12], 12'b0};
        w_sign  = instr[31];
      end
      c_fmt_csr: begin
`ifdef IMMGEN_CSR_EN
        w_imm32 = {27'b0, instr[19:15]};
`else
        w_illegal = 1'b1;
`endif
      end
      default: w_illegal = 1'b1;
    endcase
  end

  if (DATA_WIDTH > 32) begin : g_ext
    assign w_dec_imm = {{(DATA_WIDTH-32){w_sign}}, w_imm32};
  end else begin : g_noext
    assign w_dec_imm = w_imm32[DATA_WIDTH-1:0];
  end

  logic [PIPE_DEPTH-1:0] r_valid;
  logic [PIPE_DEPTH-1:0] r_ill;
  logic [DATA_WIDTH-1:0] r_imm [PIPE_DEPTH];
  logic [TAG_WIDTH-1:0]  r_tag [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] w_ready;
  logic [PIPE_DEPTH-1:0] w_src_valid;
  logic [PIPE_DEPTH-1:0] w_src_ill;
  logic [DATA_WIDTH-1:0] w_src_imm [PIPE_DEPTH];
  logic [TAG_WIDTH-1:0]  w_src_tag [PIPE_DEPTH];

  // Flattened ready chain: a stage can take data unless it and every stage
  // downstream of it are full while the consumer stalls.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_ready
    assign w_ready[k] = out_ready | ~(&r_valid[PIPE_DEPTH-1:k]);
  end

  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_ill[0]   = w_illegal;
    w_src_imm[0]   = w_dec_imm;
    w_src_tag[0]   = in_tag;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_ill[k]   = r_ill[k-1];
      w_src_imm[k]   = r_imm[k-1];
      w_src_tag[k]   = r_tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ill   <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_imm[k] <= '0;
        r_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_src_valid[k];
        end
        // Payload only moves with a valid entry, keeping bubbles quiet.
        if (!flush && w_ready[k] && w_src_valid[k]) begin
          r_ill[k] <= w_src_ill[k];
          r_imm[k] <= w_src_ill[k] ? '0 : w_src_imm[k];
          r_tag[k] <= w_src_tag[k];
        end
      end
    end
  end

  logic                    w_accept;
  logic [ERRCNT_WIDTH-1:0] r_err;

  assign w_accept = in_valid & w_ready[0] & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (w_accept && w_illegal && !(&r_err)) begin
      r_err <= r_err + ERRCNT_WIDTH'(1);
    end
  end

  assign in_ready    = w_ready[0];
  assign out_valid   = r_valid[PIPE_DEPTH-1];
  assign out_illegal = r_ill[PIPE_DEPTH-1];
  assign immext      = r_imm[PIPE_DEPTH-1];
  assign out_tag     = r_tag[PIPE_DEPTH-1];
  assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed vector bench for imm_gen_pipe (64-bit, two stages,
//            2-bit error counter). Honours IMMGEN_CSR_EN for immsrc 101.
// Revision : 1.0
// ============================================================================
module tb_imm_gen_pipe;

  localparam int DW = 64;
  localparam int PD = 2;
  localparam int TW = 32;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:7]   instr = '0;
  logic [2:0]    immsrc = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] immext;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic [EW-1:0] err_count;

  imm_gen_pipe #(
    .DATA_WIDTH  (DW),
    .PIPE_DEPTH  (PD),
    .TAG_WIDTH   (TW),
    .ERRCNT_WIDTH(EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .immsrc     (immsrc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .immext     (immext),
    .out_tag    (out_tag),
    .out_illegal(out_illegal),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  src;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [11];
  int   errors = 0;
  int   checks = 0;
  int   exp_err = 0;
  int   lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] word, input logic [2:0] src, input logic [31:0] tag);
    instr    = word[31:7];
    immsrc   = src;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Starts and ends just after a falling edge; returns one edge after the handshake.
  task automatic send(input logic [31:0] word, input logic [2:0] src, input logic [31:0] tag);
    int n;
    n = 0;
    drive(word, src, tag);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[1]  = '{32'h7FF00093, 3'b000, 64'h00000000_000007FF, 1'b0};
    vecs[2]  = '{32'h00A12423, 3'b001, 64'h00000000_00000008, 1'b0};
    vecs[3]  = '{32'hFE112E23, 3'b001, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[4]  = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[5]  = '{32'h0040006F, 3'b011, 64'h00000000_00000004, 1'b0};
    vecs[6]  = '{32'hFFDFF06F, 3'b011, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[7]  = '{32'h800000B7, 3'b100, 64'hFFFFFFFF_80000000, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 3'b110, 64'h0, 1'b1};
`ifdef IMMGEN_CSR_EN
    vecs[9]  = '{32'h800F8073, 3'b101, 64'h00000000_0000001F, 1'b0};
`else
    vecs[9]  = '{32'h800F8073, 3'b101, 64'h0, 1'b1};
`endif
    vecs[10] = '{32'hFFFFFFFF, 3'b111, 64'h0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_immext", immext, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // Single-entry vectors: latency, value, flag, tag, error count
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].word, vecs[i].src, 32'h100 + i);
      if (vecs[i].ill && exp_err < 3) exp_err++;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("tbl_latency", lat, PD);
      chk("tbl_immext", immext, vecs[i].imm);
      chk("tbl_illegal", out_illegal, vecs[i].ill);
      chk("tbl_tag", out_tag, 32'h100 + i);
      chk("tbl_err_count", err_count, exp_err);
      @(negedge clk);
    end

    // Back-to-back stream with consumer always ready: no bubbles
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_tag", out_tag, 32'h10 + i - 2);
      end
      if (i < 4) begin
        chk("stream_in_ready", in_ready, 1);
        drive(32'h00100093, 3'b000, 32'h10 + i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_drained", out_valid, 0);

    // Backpressure: fill to depth, hold stable, then drain in order
    out_ready = 1'b0;
    drive(32'h7FF00093, 3'b000, 32'd1);
    chk("stall_rdy_1", in_ready, 1);
    @(negedge clk);
    drive(32'h12345037, 3'b100, 32'd2);
    chk("stall_rdy_2", in_ready, 1);
    @(negedge clk);
    drive(32'h00A12423, 3'b001, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_tag", out_tag, 1);
      chk("stall_imm", immext, 64'h7FF);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("drain_tag_1", out_tag, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_tag_2", out_tag, 2);
    chk("drain_imm_2", immext, 64'h00000000_12345000);
    @(negedge clk);
    chk("drain_valid_3", out_valid, 1);
    chk("drain_tag_3", out_tag, 3);
    chk("drain_imm_3", immext, 64'h8);
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    // Flush with a full pipe and an illegal input presented
    do_reset();
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'b000, 32'h21);
    @(negedge clk);
    drive(32'h0040006F, 3'b011, 32'h22);
    @(negedge clk);
    drive(32'hFFFFFFFF, 3'b110, 32'h23);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_full_valid", out_valid, 0);
    chk("flush_full_err", err_count, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_full_quiet", out_valid, 0);
    end

    // Flush with an empty pipe while in_ready is high
    drive(32'hFFFFFFFF, 3'b111, 32'h24);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_empty_err", err_count, 0);
    repeat (3) begin
      chk("flush_empty_quiet", out_valid, 0);
      @(negedge clk);
    end

    // Reset together with flush, mid-stream
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'b000, 32'h31);
    @(negedge clk);
    drive(32'hFFFFFFFF, 3'b110, 32'h32);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_err_before", err_count, 1);
    chk("mid_tag_before", out_tag, 32'h31);
    rst_n = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_immext", immext, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_illegal", out_illegal, 0);
    chk("mid_rst_err", err_count, 0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_quiet", out_valid, 0);
    end

    // Saturating error counter: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      send(32'hFFFFFFFF, 3'b110, 32'h40 + i);
      chk("sat_err_count", err_count, (i < 3) ? i + 1 : 3);
      @(negedge clk);
      chk("sat_valid", out_valid, 1);
      chk("sat_immext", immext, 0);
      chk("sat_illegal", out_illegal, 1);
      chk("sat_tag", out_tag, 32'h40 + i);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
